// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and
// default bus widths.
package data_mem_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// Winner select for the data-memory arbiter: CPU priority with a bounded
// run of CPU grants while debug waits.
module mem_arb_pick
  import data_mem_pkg::*;
#(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_arb,
  input  logic    i_cpu_req,
  input  logic    i_dbg_req,
  output req_id_t o_winner
);

  localparam int               CNT_W   = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CPU_BURST);

  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    o_winner = REQ_CPU;
    if (i_dbg_req && (!i_cpu_req || (r_burst_cnt == CNT_MAX))) begin
      o_winner = REQ_DBG;
    end
  end

  // Only CPU grants made while debug is waiting extend the run; saturate, never wrap.
  always_comb begin
    w_cnt_nxt = r_burst_cnt;
    if (!i_dbg_req || (o_winner == REQ_DBG)) begin
      w_cnt_nxt = '0;
    end else if (r_burst_cnt != CNT_MAX) begin
      w_cnt_nxt = r_burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (i_arb) begin
      r_burst_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serializes CPU and debug accesses onto the single-port data memory and
// sequences the memory control signals (write: 3 cycles, read: 4 cycles).
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dbg
);

  state_t            r_state;
  state_t            w_state_nxt;
  req_id_t           w_pick;
  req_id_t           r_winner;
  logic              r_we;
  logic              r_mem_wren;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_arb;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_arb = (r_state == IDLE) && (cpu_req || dbg_req);

  mem_arb_pick #(
    .MAX_CPU_BURST(MAX_CPU_BURST)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_arb    (w_arb),
    .i_cpu_req(cpu_req),
    .i_dbg_req(dbg_req),
    .o_winner (w_pick)
  );

  always_comb begin
    w_sel_we    = cpu_we;
    w_sel_addr  = cpu_addr;
    w_sel_wdata = cpu_wdata;
    if (w_pick == REQ_DBG) begin
      w_sel_we    = dbg_we;
      w_sel_addr  = dbg_addr;
      w_sel_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cpu_req || dbg_req) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = r_we ? DONE : READ;
      READ:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // mem_wren and the acks default low each cycle, so they can only ever pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winner    <= REQ_CPU;
      r_we        <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_mem_wren <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dbg_ack  <= 1'b0;
      if (w_arb) begin
        r_winner    <= w_pick;
        r_we        <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_wren  <= w_sel_we;
      end
      if (r_state == READ) begin
        if (r_winner == REQ_DBG) begin
          r_dbg_rdata <= mem_rdata;
        end else begin
          r_cpu_rdata <= mem_rdata;
        end
      end
      if (w_state_nxt == DONE) begin
        r_cpu_ack <= (r_winner == REQ_CPU);
        r_dbg_ack <= (r_winner == REQ_DBG);
      end
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wren  = r_mem_wren;
  assign busy      = (r_state != IDLE);
  assign grant_dbg = (r_winner == REQ_DBG);

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and access sequencer for the CPU's single-port data memory (synchronous-write, 1-cycle-read altsyncram). The CPU load/store datapath is one requester. The debug port, used by the board-level register/memory viewer and the memory loader, is the other. The block serializes both onto one memory port with CPU priority and a bounded-starvation guarantee for debug, and it owns the memory control signals.

## Interface
- ADDR_W, 11, word address width of data memory
- DATA_W, 32, data word width
- MAX_CPU_BURST, 4, max consecutive CPU grants while dbg_req is pending (≥1)
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req / dbg_req  in  1  access request, held until ack
- cpu_we / dbg_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dbg_addr  in  ADDR_W  word address; stable while req high
- cpu_wdata / dbg_wdata  in  DATA_W  write data; stable while req high
- cpu_ack / dbg_ack  out  1  one-cycle completion pulse
- cpu_rdata / dbg_rdata  out  DATA_W  read data, valid while ack is high, held until the next read for that port
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_wren  out  1  memory write enable, one-cycle pulse
- mem_rdata  in  DATA_W  memory q, valid the cycle after the address edge
- busy  out  1  state ≠ IDLE
- grant_dbg  out  1  current or last grant went to debug

## Operation
- FSM states: IDLE, ACCESS, READ, DONE.
- IDLE → ACCESS:
  - Taken when any req is high at the clock edge.
  - The winner is latched, along with its addr, wdata and we.
  - mem_addr and mem_wdata are registered, and mem_wren = winner_we.
- ACCESS → DONE on a write (mem_wren drops to 0). ACCESS → READ on a read.
- READ → DONE: mem_rdata is captured into the winner's rdata register.
- DONE → IDLE unconditionally. The winner's ack is high for exactly the DONE cycle.
- Requests are sampled only in IDLE. A requester must drop req at the edge ending its ack cycle. A req still high in the next IDLE is treated as a new request.
- Priority:
  - CPU wins by default.
  - burst_cnt counts CPU grants made while dbg_req is high.
  - When burst_cnt == MAX_CPU_BURST and dbg_req is high, debug wins.
  - burst_cnt clears on a debug grant, or on any arbitration where dbg_req is low.
  - burst_cnt saturates; it never wraps.
- Only one request pending: it wins regardless of burst_cnt.
- Non-winning requests are neither acked nor dropped. They stay pending.

## Timing
- Reset values:
  - state = IDLE
  - all ack = 0
  - mem_wren = 0
  - mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0
  - busy = 0, grant_dbg = 0
  - burst_cnt = 0
- Write latency: req sampled at edge E0, memory write at E1, ack high E1–E2. Minimum 3 cycles per back-to-back write.
- Read latency: req sampled at E0, address edge E1, rdata captured at E2, ack high E2–E3. Minimum 4 cycles per back-to-back read.
- mem_wren is never high outside ACCESS. It is never high for two consecutive cycles.
- Simultaneous cpu_req and dbg_req in IDLE: exactly one grant per arbitration, never both.
- Reset asserted mid-operation: all outputs return to reset values immediately. No ack is issued.
  - A write is committed only if the E1 edge occurred before reset.
  - After reset deassertion, the first arbitration is in IDLE.

## Structure
- Package data_mem_pkg holds:
  - the state enum (IDLE/ACCESS/READ/DONE)
  - the requester-id enum (REQ_CPU/REQ_DBG)
  - default ADDR_W/DATA_W constants
- Sub-module mem_arb_pick is purely the winner select: burst_cnt compare and next-count logic, combinational plus the counter register.
- The FSM and registers live in the top module.

## Test plan
- Single CPU write, addr 10, data 11 → mem_wren pulses exactly once with mem_addr = 10, cpu_ack pulses 2 cycles after the request edge, dbg_ack stays 0.
- CPU read of addr 10 after that write → cpu_ack 3 cycles after the request edge, cpu_rdata = 11 during ack and held afterwards.
- cpu_req and dbg_req both continuously re-raised, MAX_CPU_BURST = 4 → grant sequence CPU, CPU, CPU, CPU, DBG repeating, with no ack ever lost.
- cpu_req and dbg_req raised in the same cycle, burst_cnt = 0 → CPU is served first, then debug with no idle gap beyond one IDLE cycle, and dbg_rdata is correct.
- rst_n pulled low during READ → ack never pulses, busy = 0 immediately, and a fresh request after release completes normally.
- Debug loader writes addrs 0–31 with value = addr, then the CPU reads addr 29 → cpu_rdata = 29.
